if_id_buf: RTL and testbench
============================

Name: if_id_buf

Overview:
Parametrised successor to the single-entry IF/ID register: a DEPTH-entry instruction buffer between fetch and decode. It uses a valid/ready handshake on both sides, so decode stalls back-pressure fetch without losing instructions. It provides a synchronous flush that empties the buffer and NOP substitution on invalid or faulted slots. Fetch pushes {inst, addr, fault}; decode pops from the head.

Parameters:
INST_W, 32, instruction width in bits
ADDR_W, 32, instruction address width in bits
DEPTH, 2, number of buffer entries; power of 2, range 2..8
NOP_INST, 32'h00000013, value driven on inst_o when no valid instruction is presented (addi x0,x0,0)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
flush_i  in  1  synchronous flush (branch/jump taken); highest priority
in_valid_i  in  1  fetch presents a beat
in_ready_o  out  1  buffer can accept a beat
inst_i  in  INST_W  fetched instruction
inst_addr_i  in  ADDR_W  address of inst_i
in_err_i  in  1  fetch fault for this beat (bus or alignment)
out_valid_o  out  1  head entry valid
out_ready_i  in  1  decode consumes head; low = decode stall
inst_o  out  INST_W  head instruction, or NOP_INST
inst_addr_o  out  ADDR_W  head address, or 0
err_o  out  1  head entry carries a fetch fault
count_o  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (rst=0, async): wr_ptr=0, rd_ptr=0, count=0. Outputs: out_valid_o=0, inst_o=NOP_INST, inst_addr_o=0, err_o=0, count_o=0, in_ready_o=1. Storage contents are don't-care.
- push = in_valid_i & in_ready_o & !flush_i. pop = out_valid_o & out_ready_i & !flush_i.
- in_ready_o = (count < DEPTH). It depends on registered state only, never on out_ready_i, so there is no combinational path from input to output. A full buffer does not accept a beat even when a pop occurs in the same cycle.
- out_valid_o = (count != 0). Head fields are driven combinationally from storage[rd_ptr].
- Latency: a beat pushed at edge N is visible on the outputs after edge N. There is no same-cycle bypass.
- Push writes {inst_i, inst_addr_i, in_err_i} at wr_ptr, then wr_ptr = wr_ptr+1 mod DEPTH.
- Pop advances rd_ptr = rd_ptr+1 mod DEPTH.
- Count update: push only, count+1; pop only, count-1; push and pop together, count unchanged.
- Pointer wrap-around is natural modulo DEPTH; no extra full/empty bit is needed because count is authoritative.
- Flush (flush_i=1 at an edge): count, wr_ptr and rd_ptr return to 0. A beat offered that cycle is dropped even though in_ready_o may be 1. A pop that cycle does not count as consumed.
  - The next cycle shows out_valid_o=0, inst_o=NOP_INST and inst_addr_o=0.
  - A flush on an empty buffer is a no-op apart from resetting the pointers.
- NOP substitution:
  - out_valid_o=0 gives inst_o=NOP_INST, inst_addr_o=0, err_o=0.
  - Valid head with err=1 gives inst_o=NOP_INST, inst_addr_o=stored address, err_o=1. Decode raises the fetch exception from err_o and inst_addr_o.
- Ordering: strict FIFO; no reordering and no duplication.
- Hold behaviour: while out_ready_i=0, the head outputs remain stable.
- Reset asserted mid-operation clears all state immediately and asynchronously. The first push is possible on the first edge after rst deasserts.

Test Plan:
- Reset, then push addr 0x00/inst 0x00500093 with out_ready_i=1 -> out_valid_o=1 one cycle later with inst 0x00500093/addr 0x00; pop; count_o back to 0; inst_o=0x00000013.
- DEPTH=2, out_ready_i=0, push 0x10,0x14,0x18 -> first two accepted, in_ready_o=0 at count 2, third held. Raise out_ready_i -> output order 0x10,0x14,0x18.
- Full buffer, in_valid_i=1, out_ready_i=1 -> pop only; count_o goes 2 to 1; in_ready_o returns to 1 the next cycle.
- count=2 with push offered and flush_i=1 -> next cycle count_o=0, out_valid_o=0, inst_o=0x00000013, inst_addr_o=0. Offered beat is never output.
- Push addr 0x20 with in_err_i=1 -> head shows err_o=1, inst_addr_o=0x20, inst_o=0x00000013.
- Continuous push/pop for 20 beats at DEPTH=4 (pointer wrap) -> addresses out in order 0x00..0x4C, no loss. Assert rst mid-stream -> all outputs at reset values immediately.

Source files
------------

// File: rtl/if_id_buf.sv
// if_id_buf: DEPTH-entry fetch/decode instruction buffer with valid/ready handshakes,
// synchronous flush and NOP substitution for empty or faulted head slots.
module if_id_buf #(
  parameter int INST_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH = 2,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'h00000013)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [INST_W-1:0]        inst_i,
  input  logic [ADDR_W-1:0]        inst_addr_i,
  input  logic                     in_err_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [INST_W-1:0]        inst_o,
  output logic [ADDR_W-1:0]        inst_addr_o,
  output logic                     err_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [INST_W-1:0] inst_q [DEPTH];
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic              err_q  [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic              push, pop, head_err;
  // Ready looks only at registered occupancy, so a full buffer never takes a beat
  // even when decode pops in the same cycle.
  assign in_ready_o  = count_o < FULL;
  assign out_valid_o = count_o != '0;
  assign push        = in_valid_i & in_ready_o & ~flush_i;
  assign pop         = out_valid_o & out_ready_i & ~flush_i;
  assign head_err    = err_q[rd_ptr];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst || flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      wr_ptr  <= wr_ptr + PW'(push);
      rd_ptr  <= rd_ptr + PW'(pop);
      count_o <= count_o + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      inst_q[wr_ptr] <= inst_i;
      addr_q[wr_ptr] <= inst_addr_i;
      err_q[wr_ptr]  <= in_err_i;
    end
  end
  always_comb begin
    inst_o      = (out_valid_o && !head_err) ? inst_q[rd_ptr] : NOP_INST;
    inst_addr_o = out_valid_o ? addr_q[rd_ptr] : '0;
    err_o       = out_valid_o & head_err;
  end
endmodule

// File: tb/tb_if_id_buf.sv
// tb_if_id_buf: drives a DEPTH=2 and a DEPTH=4 buffer with shared stimulus and checks
// both against a queue-based reference model.
module tb_if_id_buf;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [69:0] RST_VEC = {1'b0, 1'b1, 1'b0, 3'd0, NOP, 32'd0};
  typedef struct packed {logic [31:0] inst; logic [31:0] addr; logic err;} ent_t;
  logic clk = 0, rst = 0, flush = 0, in_valid = 0, in_err = 0, out_ready = 0;
  logic [31:0] inst = 0, addr = 0;
  logic rdy2, vld2, err2, rdy4, vld4, err4;
  logic [31:0] inst2, addr2, inst4, addr4;
  logic [1:0] cnt2;
  logic [2:0] cnt4;
  logic [69:0] obs2, obs4;
  ent_t q2[$], q4[$];
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  if_id_buf u2 (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(rdy2),
    .inst_i(inst), .inst_addr_i(addr), .in_err_i(in_err), .out_valid_o(vld2),
    .out_ready_i(out_ready), .inst_o(inst2), .inst_addr_o(addr2), .err_o(err2), .count_o(cnt2)
  );
  if_id_buf #(.DEPTH(4)) u4 (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(rdy4),
    .inst_i(inst), .inst_addr_i(addr), .in_err_i(in_err), .out_valid_o(vld4),
    .out_ready_i(out_ready), .inst_o(inst4), .inst_addr_o(addr4), .err_o(err4), .count_o(cnt4)
  );
  assign obs2 = {vld2, rdy2, err2, 1'b0, cnt2, inst2, addr2};
  assign obs4 = {vld4, rdy4, err4, cnt4, inst4, addr4};
  // Reference model: a FIFO per instance; readiness is decided on the pre-edge occupancy.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q2.delete();
      q4.delete();
    end else if (flush) begin
      q2.delete();
      q4.delete();
    end else begin
      if (in_valid && q2.size() < 2) begin
        if (q2.size() > 0 && out_ready) void'(q2.pop_front());
        q2.push_back('{inst, addr, in_err});
      end else if (q2.size() > 0 && out_ready) void'(q2.pop_front());
      if (in_valid && q4.size() < 4) begin
        if (q4.size() > 0 && out_ready) void'(q4.pop_front());
        q4.push_back('{inst, addr, in_err});
      end else if (q4.size() > 0 && out_ready) void'(q4.pop_front());
    end
  end
  function automatic logic [69:0] exp_vec(int s);
    int n;
    ent_t e;
    n = s ? q4.size() : q2.size();
    if (n == 0) return RST_VEC;
    e = s ? q4[0] : q2[0];
    return {1'b1, n < (s ? 4 : 2), e.err, 3'(n), e.err ? NOP : e.inst, e.addr};
  endfunction
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    in_valid = 0; flush = 0; in_err = 0; out_ready = 0;
  endtask
  task automatic test_reset();
    idle();
    rst = 0;
    cyc();
    n_chk++;
    if (obs2 !== RST_VEC || obs4 !== RST_VEC)
      $display("FAIL reset: got d2=%h d4=%h want %h", obs2, obs4, RST_VEC);
    else n_pass++;
    rst = 1;
  endtask
  task automatic test_basic();
    in_valid = 1; inst = 32'h00500093; addr = 32'h0; out_ready = 1;
    cyc();
    in_valid = 0;
    n_chk++;
    if (vld2 !== 1 || inst2 !== 32'h00500093 || addr2 !== 0 || cnt2 !== 1)
      $display("FAIL basic_push: got v=%b inst=%h addr=%h cnt=%0d want v=1 inst=00500093 addr=0 cnt=1", vld2, inst2, addr2, cnt2);
    else n_pass++;
    cyc();
    n_chk++;
    if (cnt2 !== 0 || inst2 !== NOP || vld2 !== 0)
      $display("FAIL basic_pop: got cnt=%0d inst=%h v=%b want cnt=0 inst=%h v=0", cnt2, inst2, vld2, NOP);
    else n_pass++;
  endtask
  task automatic test_backpressure();
    out_ready = 0; in_valid = 1; inst = 32'h11111111;
    addr = 32'h10; cyc();
    addr = 32'h14; cyc();
    n_chk++;
    if (rdy2 !== 0 || cnt2 !== 2)
      $display("FAIL bp_full: got ready=%b cnt=%0d want ready=0 cnt=2", rdy2, cnt2);
    else n_pass++;
    addr = 32'h18; cyc();
    n_chk++;
    if (cnt2 !== 2 || addr2 !== 32'h10 || obs4 !== exp_vec(1))
      $display("FAIL bp_hold: got cnt=%0d head=%h d4=%h want cnt=2 head=10 d4=%h", cnt2, addr2, obs4, exp_vec(1));
    else n_pass++;
    out_ready = 1; cyc();
    n_chk++;
    if (cnt2 !== 1 || rdy2 !== 1 || addr2 !== 32'h14)
      $display("FAIL full_pop_only: got cnt=%0d ready=%b head=%h want cnt=1 ready=1 head=14", cnt2, rdy2, addr2);
    else n_pass++;
    cyc();
    in_valid = 0;
    n_chk++;
    if (addr2 !== 32'h18 || cnt2 !== 1 || obs4 !== exp_vec(1))
      $display("FAIL bp_order: got head=%h cnt=%0d d4=%h want head=18 cnt=1 d4=%h", addr2, cnt2, obs4, exp_vec(1));
    else n_pass++;
    cyc();
  endtask
  task automatic test_flush();
    flush = 1; cyc(); flush = 0;
    out_ready = 0; in_valid = 1;
    addr = 32'h30; cyc();
    addr = 32'h34; cyc();
    addr = 32'h38; flush = 1; cyc();
    flush = 0; in_valid = 0;
    n_chk++;
    if (obs2 !== RST_VEC || obs4 !== RST_VEC)
      $display("FAIL flush: got d2=%h d4=%h want %h", obs2, obs4, RST_VEC);
    else n_pass++;
    out_ready = 1; cyc();
    n_chk++;
    if (vld2 !== 0 || vld4 !== 0)
      $display("FAIL flush_drop: got v2=%b v4=%b want 0 0", vld2, vld4);
    else n_pass++;
  endtask
  task automatic test_err();
    out_ready = 0; in_valid = 1; in_err = 1; addr = 32'h20; inst = 32'hdeadbeef;
    cyc();
    in_valid = 0; in_err = 0;
    n_chk++;
    if (err2 !== 1 || addr2 !== 32'h20 || inst2 !== NOP || vld2 !== 1)
      $display("FAIL err_nop: got err=%b addr=%h inst=%h v=%b want err=1 addr=20 inst=%h v=1", err2, addr2, inst2, vld2, NOP);
    else n_pass++;
    flush = 1; cyc(); flush = 0;
  endtask
  task automatic test_wrap();
    int k = 0;
    out_ready = 1; in_valid = 1; inst = 32'h00000033;
    for (int i = 0; i < 20; i++) begin
      addr = 32'(i * 4);
      cyc();
      n_chk++;
      if (addr4 !== 32'(k * 4) || vld4 !== 1 || obs2 !== exp_vec(0))
        $display("FAIL wrap_%0d: got addr4=%h v4=%b d2=%h want addr4=%h v4=1 d2=%h", i, addr4, vld4, obs2, 32'(k * 4), exp_vec(0));
      else n_pass++;
      k++;
    end
    #2 rst = 0;
    #1;
    n_chk++;
    if (obs2 !== RST_VEC || obs4 !== RST_VEC)
      $display("FAIL async_reset: got d2=%h d4=%h want %h", obs2, obs4, RST_VEC);
    else n_pass++;
    cyc();
    rst = 1;
    in_valid = 1; out_ready = 0; addr = 32'h100;
    cyc();
    in_valid = 0;
    n_chk++;
    if (vld4 !== 1 || addr4 !== 32'h100 || cnt4 !== 1)
      $display("FAIL first_push: got v4=%b addr4=%h cnt4=%0d want v4=1 addr4=100 cnt4=1", vld4, addr4, cnt4);
    else n_pass++;
  endtask
  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_err    = ($urandom_range(0, 7) == 0);
      inst      = $urandom;
      addr      = 32'(i * 4);
      cyc();
      n_chk++;
      if (obs2 !== exp_vec(0) || obs4 !== exp_vec(1))
        $display("FAIL random_%0d: got d2=%h d4=%h want d2=%h d4=%h", i, obs2, obs4, exp_vec(0), exp_vec(1));
      else n_pass++;
    end
    idle();
  endtask
  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_flush();
    test_err();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
